// File: rtl/life_support_ctrl.sv
// Multi-deck life-support and hull controller: shared power, shield and cabin temperature,
// per-deck O2, ship-state FSM and a latched loss-of-crew flag after a persistent hazard.
module life_support_ctrl #(
  parameter int unsigned W          = 32,
  parameter int unsigned DECKS      = 4,
  parameter int unsigned SHIELD_MAX = 200,
  parameter int unsigned TEMP_LIMIT = 100,
  parameter int unsigned ATK_DMG    = 5,
  parameter int unsigned GRACE      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [W-1:0]       pwr_in,
  input  logic [W-1:0]       shield_in,
  input  logic [W-1:0]       temp_in,
  input  logic [DECKS*W-1:0] o2_in,
  input  logic               chrg,
  input  logic [DECKS-1:0]   o2sup,
  input  logic               atk,
  input  logic [3:0]         mode,
  output logic [W-1:0]       outpower,
  output logic [W-1:0]       outshield,
  output logic [W-1:0]       outtemp,
  output logic [DECKS*W-1:0] outo2,
  output logic [1:0]         state,
  output logic [DECKS-1:0]   warn,
  output logic               fatal
);

  typedef enum logic [1:0] {
    StNormal   = 2'b00,
    StDefense  = 2'b01,
    StStealth  = 2'b10,
    StCritical = 2'b11
  } state_e;

  localparam int unsigned CW = $clog2(GRACE + 1);
  localparam logic [W-1:0]  ShieldMax = W'(SHIELD_MAX);
  localparam logic [W-1:0]  TempLimit = W'(TEMP_LIMIT);
  localparam logic [W-1:0]  AtkDmg    = W'(ATK_DMG);
  localparam logic [CW-1:0] GraceMax  = CW'(GRACE);
  localparam logic [CW-1:0] GraceLast = CW'(GRACE - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  power_q, power_d;
  logic [W-1:0]  shield_q, shield_d;
  logic [W-1:0]  temp_q, temp_d;
  logic [W-1:0]  o2_q [DECKS];
  logic [W-1:0]  o2_d [DECKS];
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          fatal_q, fatal_d;
  logic          armed_q, armed_d;

  logic hot;
  logic any_o2_zero;
  logic hazard;

  always_comb begin
    hot         = temp_q >= TempLimit;
    any_o2_zero = 1'b0;
    for (int i = 0; i < DECKS; i++) begin
      any_o2_zero = any_o2_zero | (o2_q[i] == '0);
    end
    hazard = armed_q & (hot | any_o2_zero | (shield_q == '0));
  end

  always_comb begin
    state_d  = state_q;
    power_d  = power_q;
    shield_d = shield_q;
    temp_d   = temp_q;
    o2_d     = o2_q;
    hcnt_d   = hcnt_q;
    fatal_d  = fatal_q;
    armed_d  = armed_q;

    if (load) begin
      power_d  = pwr_in;
      shield_d = shield_in;
      temp_d   = temp_in;
      for (int i = 0; i < DECKS; i++) begin
        o2_d[i] = o2_in[i*W +: W];
      end
      armed_d = 1'b1;
      hcnt_d  = '0;
      state_d = StNormal;
    end else begin
      // CRITICAL ignores mode; it drops out as soon as the hazard is gone.
      if (hazard) begin
        state_d = StCritical;
      end else if (power_q == '0) begin
        state_d = StNormal;
      end else if (mode == 4'b0100) begin
        state_d = StDefense;
      end else if (mode == 4'b1000) begin
        state_d = StStealth;
      end else begin
        state_d = StNormal;
      end

      if (chrg) begin
        power_d = pwr_in;
      end else if (state_q == StDefense) begin
        power_d = (power_q >= W'(2)) ? power_q - W'(2) : '0;
      end else begin
        power_d = (power_q != '0) ? power_q - W'(1) : '0;
      end

      if (atk) begin
        shield_d = (shield_q >= AtkDmg) ? shield_q - AtkDmg : '0;
      end else if ((state_q == StDefense) && (shield_q < ShieldMax)) begin
        shield_d = shield_q + W'(1);
      end

      if (state_q == StStealth) begin
        temp_d = (temp_q == '1) ? temp_q : temp_q + W'(1);
      end else if ((power_q != '0) && (temp_q != '0)) begin
        temp_d = temp_q - W'(1);
      end

      for (int i = 0; i < DECKS; i++) begin
        if (o2sup[i]) begin
          o2_d[i] = o2_in[i*W +: W];
        end else begin
          o2_d[i] = (o2_q[i] != '0) ? o2_q[i] - W'(1) : '0;
        end
      end

      if (hazard) begin
        if (hcnt_q >= GraceLast) begin
          hcnt_d  = GraceMax;
          fatal_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end else begin
        hcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StNormal;
      power_q  <= '0;
      shield_q <= '0;
      temp_q   <= '0;
      o2_q     <= '{default: '0};
      hcnt_q   <= '0;
      fatal_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      power_q  <= power_d;
      shield_q <= shield_d;
      temp_q   <= temp_d;
      o2_q     <= o2_d;
      hcnt_q   <= hcnt_d;
      fatal_q  <= fatal_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    outpower  = power_q;
    outshield = shield_q;
    outtemp   = temp_q;
    state     = state_q;
    fatal     = fatal_q;
    for (int i = 0; i < DECKS; i++) begin
      outo2[i*W +: W] = o2_q[i];
      warn[i]         = armed_q & ((o2_q[i] == '0) | hot);
    end
  end

endmodule

// File: tb/tb_life_support_ctrl.sv
// Directed bench for life_support_ctrl: hand-computed expectations checked with immediate
// assertions after each clock step.
module tb_life_support_ctrl;

  localparam int unsigned W     = 32;
  localparam int unsigned DECKS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [W-1:0]       pwr_in, shield_in, temp_in;
  logic [DECKS*W-1:0] o2_in;
  logic               chrg;
  logic [DECKS-1:0]   o2sup;
  logic               atk;
  logic [3:0]         mode;
  logic [W-1:0]       outpower, outshield, outtemp;
  logic [DECKS*W-1:0] outo2;
  logic [1:0]         state;
  logic [DECKS-1:0]   warn;
  logic               fatal;

  int vectors     = 0;
  int miscompares = 0;

  life_support_ctrl #(
    .W(W), .DECKS(DECKS), .SHIELD_MAX(200), .TEMP_LIMIT(100), .ATK_DMG(5), .GRACE(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pwr_in    (pwr_in),
    .shield_in (shield_in),
    .temp_in   (temp_in),
    .o2_in     (o2_in),
    .chrg      (chrg),
    .o2sup     (o2sup),
    .atk       (atk),
    .mode      (mode),
    .outpower  (outpower),
    .outshield (outshield),
    .outtemp   (outtemp),
    .outo2     (outo2),
    .state     (state),
    .warn      (warn),
    .fatal     (fatal)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] s, input logic [W-1:0] t,
                         input logic [W-1:0] o);
    pwr_in    = p;
    shield_in = s;
    temp_in   = t;
    o2_in     = {DECKS{o}};
    load      = 1'b1;
    step(1);
    load      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; chrg = 1'b1; atk = 1'b0; o2sup = '1; mode = 4'b0100;
    pwr_in = 55; shield_in = 66; temp_in = 77; o2_in = {DECKS{32'd88}};
    // Reset held low while load is high: reset must win.
    step(2);
    check("rst_power", outpower, 0);
    check("rst_shield", outshield, 0);
    check("rst_state", state, 0);

    rst = 1'b1; load = 1'b0; chrg = 1'b0; o2sup = '0; mode = 4'b0000;
    step(20);
    check("idle_power", outpower, 0);
    check("idle_shield", outshield, 0);
    check("idle_temp", outtemp, 0);
    check("idle_o2", outo2, 0);
    check("idle_state", state, 0);
    check("idle_warn", warn, 0);
    check("idle_fatal", fatal, 0);

    // Defense entry and recharge latency.
    mode = 4'b0100;
    do_load(50, 10, 20, 30);
    check("def_load_state", state, 0);
    check("def_load_power", outpower, 50);
    step(1);
    check("def_state", state, 1);
    check("def_power1", outpower, 49);
    check("def_shield1", outshield, 10);
    step(1);
    check("def_shield2", outshield, 11);
    check("def_power2", outpower, 47);
    check("def_temp2", outtemp, 18);
    check("def_o2", outo2, {DECKS{32'd28}});
    check("def_warn", warn, 0);

    // Shield ceiling with an attack pulse; load beats atk and chrg.
    o2sup = '1; atk = 1'b1; chrg = 1'b1;
    do_load(1000, 199, 20, 30);
    atk = 1'b0; chrg = 1'b0;
    check("ld_beats_atk", outshield, 199);
    check("ld_beats_chrg", outpower, 1000);
    step(1);
    check("shm_state", state, 1);
    check("shm_hold", outshield, 199);
    atk = 1'b1;
    step(1);
    atk = 1'b0;
    check("shm_atk", outshield, 194);
    step(6);
    check("shm_recharge", outshield, 200);
    step(1);
    check("shm_ceiling", outshield, 200);

    // Stealth heating into CRITICAL, then fatal after the grace period.
    mode = 4'b1000;
    do_load(3, 50, 99, 30);
    step(1);
    check("st_state", state, 2);
    check("st_temp1", outtemp, 98);
    step(1);
    check("st_temp2", outtemp, 99);
    step(1);
    check("st_temp3", outtemp, 100);
    check("st_power0", outpower, 0);
    check("st_warn", warn, 4'hF);
    check("st_not_crit", state, 2);
    step(1);
    check("st_crit", state, 3);
    check("st_temp4", outtemp, 101);
    step(6);
    check("st_fatal_early", fatal, 0);
    check("st_temp_hold", outtemp, 101);
    step(1);
    check("st_fatal_set", fatal, 1);
    step(3);
    check("st_fatal_sticky", fatal, 1);
    mode = 4'b0000;
    do_load(1000, 50, 20, 30);
    check("ld_keeps_fatal", fatal, 1);
    check("ld_state_norm", state, 0);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("rst_clears_fatal", fatal, 0);
    check("rst_clears_power", outpower, 0);

    // Deck 2 runs dry, resupplied on the 5th hazard cycle.
    o2sup = 4'b1011;
    pwr_in = 1000; shield_in = 50; temp_in = 20;
    o2_in = {DECKS{32'd30}};
    o2_in[2*W +: W] = 1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("o2_load_warn", warn, 0);
    step(1);
    check("o2_deck2_zero", outo2[2*W +: W], 0);
    check("o2_deck0", outo2[0 +: W], 30);
    check("o2_warn", warn, 4'b0100);
    check("o2_state_norm", state, 0);
    step(1);
    check("o2_crit", state, 3);
    step(3);
    o2_in[2*W +: W] = 30;
    o2sup = '1;
    step(1);
    check("o2_still_crit", state, 3);
    check("o2_resupplied", outo2[2*W +: W], 30);
    check("o2_fatal0", fatal, 0);
    step(1);
    check("o2_exit_crit", state, 0);
    check("o2_warn_clear", warn, 0);
    // Fresh hazard must need the full grace period again.
    o2_in[2*W +: W] = 0;
    step(1);
    check("o2_rehazard_warn", warn, 4'b0100);
    step(7);
    check("o2_cnt_cleared", fatal, 0);
    check("o2_rehazard_crit", state, 3);
    step(1);
    check("o2_fatal_grace", fatal, 1);

    // Power runs out in defense: fall to NORMAL, no cooling, then recharge.
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    o2sup = '1; mode = 4'b0100;
    do_load(2, 50, 20, 30);
    step(1);
    check("pw_state_def", state, 1);
    check("pw_power1", outpower, 1);
    step(1);
    check("pw_power0", outpower, 0);
    check("pw_temp", outtemp, 18);
    step(1);
    check("pw_state_norm", state, 0);
    check("pw_temp_hold1", outtemp, 18);
    step(1);
    check("pw_temp_hold2", outtemp, 18);
    chrg = 1'b1; pwr_in = 77;
    step(1);
    chrg = 1'b0;
    check("pw_chrg", outpower, 77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
